// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: active-low segment
// patterns {g,f,e,d,c,b,a} for hex digits and the all-off codes.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern lookup.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed hex display driver: latches a 32-bit word and
// rotates the active-low anodes one digit per REFRESH_DIV clock cycles.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int DIV_W       = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] din,
  input  logic [7:0]  blank,
  input  logic [7:0]  dp,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        tick
);

  logic [DIV_W-1:0] cnt;
  logic [2:0]       idx;
  logic [2:0]       idx_next;
  logic [31:0]      val;
  logic [7:0]       blk;
  logic [7:0]       pnt;
  logic [6:0]       seg_next;

  assign tick     = (cnt == DIV_W'(REFRESH_DIV - 1));
  assign idx_next = idx + 3'd1;

  // Decode the digit about to be selected so the outputs switch on the tick edge.
  hex_to_seg7 u_hex (
    .nib (val[{idx_next, 2'b00} +: 4]),
    .seg (seg_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= 3'd7;
    end else begin
      cnt <= tick ? '0 : cnt + DIV_W'(1);
      if (tick) idx <= idx_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val <= '0;
      blk <= '0;
      pnt <= '0;
    end else if (load) begin
      val <= din;
      blk <= blank;
      pnt <= dp;
    end
  end

  // Output update sees the pre-load shadow, so a coincident load waits a slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an   <= AN_OFF;
      seg  <= SEG_OFF;
      dp_n <= 1'b1;
    end else if (tick) begin
      if (blk[idx_next]) begin
        an   <= AN_OFF;
        seg  <= SEG_OFF;
        dp_n <= 1'b1;
      end else begin
        an   <= ~(8'b1 << idx_next);
        seg  <= seg_next;
        dp_n <= ~pnt[idx_next];
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with a 4-cycle digit slot.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [31:0] din = '0;
  logic [7:0]  blank = '0;
  logic [7:0]  dp = '0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        tick;

  int total = 0;
  int bad   = 0;

  logic [6:0]  hex_tb [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Reference state: shadow copy and digit index.
  logic [31:0] m_val = '0;
  logic [7:0]  m_blk = '0;
  logic [7:0]  m_pnt = '0;
  logic [2:0]  m_idx = 3'd7;
  logic [15:0] sb [$];
  logic [15:0] e;

  seg7_scan_driver #(.REFRESH_DIV(4), .DIV_W(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .din   (din),
    .blank (blank),
    .dp    (dp),
    .an    (an),
    .seg   (seg),
    .dp_n  (dp_n),
    .tick  (tick)
  );

  always #5 clk = ~clk;

  // Advance one cycle from a negedge; a visible tick pushes the expected display.
  task automatic clock_one(output bit ticked);
    logic [2:0] k;
    ticked = 1'b0;
    if (tick === 1'b1) begin
      k = m_idx + 3'd1;
      if (m_blk[k]) sb.push_back({8'hFF, 7'h7F, 1'b1});
      else          sb.push_back({~(8'b1 << k), hex_tb[m_val[{k, 2'b00} +: 4]], ~m_pnt[k]});
      m_idx  = k;
      ticked = 1'b1;
    end
    if (load === 1'b1) begin
      m_val = din;
      m_blk = blank;
      m_pnt = dp;
    end
    @(negedge clk);
  endtask

  task automatic next_slot();
    bit t = 1'b0;
    int n = 0;
    while (!t && n < 40) begin
      clock_one(t);
      n++;
    end
    if (!t) begin
      total++; bad++;
      $display("FAIL slot_timeout: no tick within %0d cycles, required one", n);
    end
  endtask

  task automatic pop_cmp(input string name);
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, required an expected entry", name);
    end else begin
      e = sb.pop_front();
      if ({an, seg, dp_n} !== e) begin
        bad++;
        $display("FAIL %s: got an=%h seg=%h dp_n=%b, required an=%h seg=%h dp_n=%b",
                 name, an, seg, dp_n, e[15:8], e[7:1], e[0]);
      end
    end
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] b, input logic [7:0] p);
    bit t;
    load = 1'b1; din = d; blank = b; dp = p;
    clock_one(t);
    load = 1'b0;
    if (t) pop_cmp("load_slot");
  endtask

  task automatic align(input logic [2:0] target);
    int n = 0;
    while (m_idx != target && n < 16) begin
      next_slot();
      pop_cmp("align");
      n++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    total++;
    if (an !== 8'hFF || seg !== 7'h7F || dp_n !== 1'b1 || tick !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: an=%h seg=%h dp_n=%b tick=%b, required FF 7F 1 0", an, seg, dp_n, tick);
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      total++;
      if (tick !== 1'b0 || an !== 8'hFF || seg !== 7'h7F) begin
        bad++;
        $display("FAIL pre_tick c%0d: tick=%b an=%h seg=%h, required 0 FF 7F", c, tick, an, seg);
      end
      @(negedge clk);
    end
    total++;
    if (tick !== 1'b1) begin
      bad++;
      $display("FAIL first_tick: tick=%b on cycle 3, required 1", tick);
    end
    next_slot();
    total++;
    if (an !== 8'hFE || seg !== 7'h40) begin
      bad++;
      $display("FAIL first_digit: an=%h seg=%h, required FE 40", an, seg);
    end
    pop_cmp("first_digit_sb");
  endtask

  task automatic test_scan();
    logic [7:0] an_exp  [9] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};
    logic [6:0] seg_exp [9] = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00, 7'h0E};
    do_load(32'h89ABCDEF, 8'h00, 8'h00);
    align(3'd7);
    for (int k = 0; k < 9; k++) begin
      next_slot();
      total++;
      if (an !== an_exp[k] || seg !== seg_exp[k] || dp_n !== 1'b1) begin
        bad++;
        $display("FAIL scan_%0d: an=%h seg=%h dp_n=%b, required %h %h 1", k, an, seg, dp_n, an_exp[k], seg_exp[k]);
      end
      pop_cmp("scan_sb");
    end
  endtask

  task automatic test_blank_dp();
    do_load(32'h00001234, 8'hF0, 8'h01);
    align(3'd7);
    for (int k = 0; k < 8; k++) begin
      next_slot();
      total++;
      if (k >= 4 && (an !== 8'hFF || seg !== 7'h7F || dp_n !== 1'b1)) begin
        bad++;
        $display("FAIL blank_%0d: an=%h seg=%h dp_n=%b, required FF 7F 1", k, an, seg, dp_n);
      end else if (k == 0 && (seg !== 7'h19 || dp_n !== 1'b0 || an !== 8'hFE)) begin
        bad++;
        $display("FAIL dp_digit0: an=%h seg=%h dp_n=%b, required FE 19 0", an, seg, dp_n);
      end else if (k > 0 && k < 4 && dp_n !== 1'b1) begin
        bad++;
        $display("FAIL dp_off_%0d: dp_n=%b, required 1", k, dp_n);
      end
      pop_cmp("blank_sb");
    end
  endtask

  task automatic test_load_on_tick();
    bit t;
    int n = 0;
    do_load(32'h00001234, 8'h00, 8'h00);
    align(3'd1);
    while (tick !== 1'b1 && n < 40) begin
      clock_one(t);
      n++;
    end
    load = 1'b1; din = 32'hFFFFFFFF; blank = 8'h00; dp = 8'h00;
    clock_one(t);
    load = 1'b0;
    total++;
    if (!t || an !== 8'hFB || seg !== 7'h24) begin
      bad++;
      $display("FAIL coincident_load: an=%h seg=%h, required FB 24 (old nibble)", an, seg);
    end
    pop_cmp("coincident_sb");
    for (int k = 3; k < 5; k++) begin
      next_slot();
      total++;
      if (seg !== 7'h0E) begin
        bad++;
        $display("FAIL new_value_d%0d: seg=%h, required 0E", k, seg);
      end
      pop_cmp("new_value_sb");
    end
  endtask

  task automatic test_reset_mid_scan();
    bit t;
    align(3'd5);
    clock_one(t);
    rst = 1'b1;
    #1;
    total++;
    if (an !== 8'hFF || seg !== 7'h7F || dp_n !== 1'b1 || tick !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: an=%h seg=%h dp_n=%b tick=%b, required FF 7F 1 0", an, seg, dp_n, tick);
    end
    sb.delete();
    m_val = '0; m_blk = '0; m_pnt = '0; m_idx = 3'd7;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    next_slot();
    total++;
    if (an !== 8'hFE || seg !== 7'h40) begin
      bad++;
      $display("FAIL restart_scan: an=%h seg=%h, required FE 40", an, seg);
    end
    pop_cmp("restart_sb");
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blank_dp();
    test_load_on_tick();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
